// File: rtl/priority_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_dec_pkg
// Description : Shared constants, FSM state type and one-hot decode helper
//               for the 2-to-4 priority decoder (receive side of the 4-to-2
//               priority encoder link).
// Contents    : N_LINES  - number of decoded output lines
//               CODE_W   - width of an encoded line index
//               state_t  - decoder FSM state (IDLE / HOLD)
//               decode_onehot() - line index to one-hot line vector
// Revision    : 1.0 - initial release
// ============================================================================
package priority_dec_pkg;

    localparam int N_LINES = 4;
    localparam int CODE_W  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_LINES-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        logic [N_LINES-1:0] w_onehot;
        w_onehot       = '0;
        w_onehot[code] = 1'b1;
        return w_onehot;
    endfunction

endpackage : priority_dec_pkg
`default_nettype wire

// File: rtl/sync_fifo_v.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_v
// Description : Parameterised single-clock FIFO with occupancy count.
//               Pushes into a full FIFO and pops from an empty FIFO are
//               ignored. Read data is the current head (show-ahead).
// Ports       : i_clk    - clock, rising edge
//               i_rst    - asynchronous active-high reset (empties the FIFO)
//               i_push   - write i_data at the tail
//               i_data   - data to write
//               i_pop    - remove the head entry
//               o_data   - head entry (valid when !o_empty)
//               o_full   - FIFO holds DEPTH entries
//               o_empty  - FIFO holds no entries
//               o_count  - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_v #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_occ_w = $clog2(DEPTH+1);

    localparam logic [c_aw-1:0]    c_ptr_one = 1;
    localparam logic [c_occ_w-1:0] c_occ_one = 1;
    localparam logic [c_occ_w-1:0] c_occ_max = c_occ_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_occ_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_occ_max);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_occ_one;
                2'b01:   r_count <= r_count - c_occ_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo_v
`default_nettype wire

// File: rtl/priority_dec_2_4_v.sv
`default_nettype none
// ============================================================================
// Module      : priority_dec_2_4_v
// Description : Receive-side 2-to-4 line decoder. Buffers 2-bit line codes
//               from a valid/ready stream and replays each as a one-hot
//               4-line output held for HOLD_CYCLES cycles, back to back
//               while codes are available.
// Ports       : i_clk    - clock, rising edge
//               i_rst    - asynchronous active-high reset
//               i_code   - encoded line index (0..3)
//               i_valid  - i_code is valid this cycle
//               o_ready  - a code can be accepted (FIFO not full, not reset)
//               o_line   - registered one-hot line, 0000 when idle
//               o_code   - registered code being held, 00 when idle
//               o_active - a code is being held
//               o_count  - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module priority_dec_2_4_v
    import priority_dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [CODE_W-1:0]               i_code,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [N_LINES-1:0]              o_line,
    output logic [CODE_W-1:0]               o_code,
    output logic                            o_active,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

    localparam int c_cnt_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = 1;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [N_LINES-1:0]   r_line;
    logic [CODE_W-1:0]    r_code;

    logic                 w_full;
    logic                 w_empty;
    logic [CODE_W-1:0]    w_head;
    logic                 w_push;
    logic                 w_pop;

    // Ready depends only on registered occupancy (and reset), never on i_valid.
    assign o_ready  = !w_full && !i_rst;
    assign w_push   = i_valid && o_ready;

    // Pop whenever the output slot frees up: from IDLE, or on the last hold
    // cycle, so consecutive codes are replayed without a gap.
    assign w_pop    = !w_empty && ((r_state == IDLE) || (r_cnt == '0));

    assign o_line   = r_line;
    assign o_code   = r_code;
    assign o_active = (r_state == HOLD);

    sync_fifo_v #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_code),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_code  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_line  <= decode_onehot(w_head);
                        r_code  <= w_head;
                        r_cnt   <= c_hold_load;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (w_pop) begin
                        r_line <= decode_onehot(w_head);
                        r_code <= w_head;
                        r_cnt  <= c_hold_load;
                    end else begin
                        r_line  <= '0;
                        r_code  <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_line  <= '0;
                    r_code  <= '0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : priority_dec_2_4_v
`default_nettype wire
